// File: rtl/bram_array.sv
// Byte-writable dual-port RAM built from SB_RAM256x16 blocks, with a post-reset zeroing sweep.
// Optional same-address read/write forwarding is enabled by defining BRAM_ARRAY_BYPASS_EN.
module bram_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int unsigned LANES  = DATA_W / 16;
    localparam int unsigned BANKS  = DEPTH / 256;
    localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [ADDR_W-1:0]   clr_cnt_d;
    logic                clr_active_c;

    logic                rd_en_c;
    logic                user_wr_c;
    logic                ram_we_c;
    logic [ADDR_W-1:0]   ram_waddr_c;
    logic [DATA_W-1:0]   ram_wdata_c;
    logic [DATA_W/8-1:0] ram_wbe_c;
    logic [BANK_W-1:0]   rd_bank_c;
    logic [BANK_W-1:0]   wr_bank_c;

    logic [BANK_W-1:0]   rbank_q;
    logic                rd_loaded_q;
    logic [15:0]         bank_rdata [BANKS][LANES];
    logic [DATA_W-1:0]   ram_rdata_c;
    logic [DATA_W-1:0]   merged_c;

    // State, clear counter and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy      <= (state_d == CLEAR);
        end
    end

    // Clear sweep walks every address once, then hands over to user traffic
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_active_c = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_active_c = 1'b1;
                clr_cnt_d    = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign rd_en_c     = re && (state_q == READY);
    assign user_wr_c   = we && (state_q == READY);
    assign ram_we_c    = clr_active_c || user_wr_c;
    assign ram_waddr_c = clr_active_c ? clr_cnt_q : waddr;
    assign ram_wdata_c = clr_active_c ? '0 : wdata;
    assign ram_wbe_c   = clr_active_c ? '1 : wbe;

    generate
        if (BANKS > 1) begin : g_bank_sel
            assign rd_bank_c = raddr[ADDR_W-1:8];
            assign wr_bank_c = ram_waddr_c[ADDR_W-1:8];
        end else begin : g_single_bank
            assign rd_bank_c = '0;
            assign wr_bank_c = '0;
        end
    endgenerate

    // Read-side bookkeeping: bank select for the output mux and valid strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid      <= 1'b0;
            rbank_q     <= '0;
            rd_loaded_q <= 1'b0;
        end else begin
            rvalid <= rd_en_c;
            if (rd_en_c) begin
                rbank_q     <= rd_bank_c;
                rd_loaded_q <= 1'b1;
            end
        end
    end

    // Primitive array; MASK is active-low, so a set byte enable clears its mask bits
    generate
        for (genvar b = 0; b < BANKS; b++) begin : g_bank
            for (genvar l = 0; l < LANES; l++) begin : g_lane
                SB_RAM256x16 u_ram (
                    .RDATA (bank_rdata[b][l]),
                    .RADDR (raddr[7:0]),
                    .RCLK  (clk),
                    .RCLKE (1'b1),
                    .RE    (rd_en_c && (rd_bank_c == BANK_W'(b))),
                    .WADDR (ram_waddr_c[7:0]),
                    .WCLK  (clk),
                    .WCLKE (1'b1),
                    .WE    (ram_we_c && (wr_bank_c == BANK_W'(b))),
                    .WDATA (ram_wdata_c[16*l +: 16]),
                    .MASK  (~{{8{ram_wbe_c[2*l+1]}}, {8{ram_wbe_c[2*l]}}})
                );
            end
        end
    endgenerate

    always_comb begin
        ram_rdata_c = '0;
        for (int unsigned b = 0; b < BANKS; b++) begin
            if (rbank_q == BANK_W'(b)) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    ram_rdata_c[16*l +: 16] = bank_rdata[b][l];
                end
            end
        end
    end

`ifdef BRAM_ARRAY_BYPASS_EN
    localparam int unsigned BE_W = DATA_W / 8;

    logic              fwd_hit_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [BE_W-1:0]   fwd_be_q;

    // Capture the colliding write alongside the read so the merge tracks rdata
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
        end else if (rd_en_c) begin
            fwd_hit_q  <= user_wr_c && (raddr == waddr);
            fwd_data_q <= wdata;
            fwd_be_q   <= wbe;
        end
    end

    always_comb begin
        merged_c = ram_rdata_c;
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (fwd_hit_q && fwd_be_q[b]) begin
                merged_c[8*b +: 8] = fwd_data_q[8*b +: 8];
            end
        end
    end
`else
    assign merged_c = ram_rdata_c;
`endif

    // Primitive output registers are not reset, so gate until the first read lands
    assign rdata = rd_loaded_q ? merged_c : '0;

endmodule

// Behavioural model of the 256x16 block RAM: registered read, per-bit active-low write mask.
module SB_RAM256x16 (
    output logic [15:0] RDATA,
    input  logic [7:0]  RADDR,
    input  logic        RCLK,
    input  logic        RCLKE,
    input  logic        RE,
    input  logic [7:0]  WADDR,
    input  logic        WCLK,
    input  logic        WCLKE,
    input  logic        WE,
    input  logic [15:0] WDATA,
    input  logic [15:0] MASK
);

    logic [15:0] mem [256];

    always_ff @(posedge RCLK) begin
        if (RE && RCLKE) begin
            RDATA <= mem[RADDR];
        end
    end

    always_ff @(posedge WCLK) begin
        if (WE && WCLKE) begin
            mem[WADDR] <= (mem[WADDR] & MASK) | (WDATA & ~MASK);
        end
    end

endmodule

// File: tb/tb_bram_array.sv
// Directed bench for bram_array: clear sweep, byte writes, collisions, bank edges, reset restarts.
module tb_bram_array;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;

`ifdef BRAM_ARRAY_BYPASS_EN
    localparam logic [31:0] EXP_COLL = 32'hAAAA5678;
`else
    localparam logic [31:0] EXP_COLL = 32'hAAAAAAAA;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wbe;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              busy;

    int tests = 0;
    int fails = 0;
    int cyc;
    bit rv_seen;

    typedef struct {
        logic        re;
        logic [9:0]  raddr;
        logic        we;
        logic [9:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [22];

    bram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .re     (re),
        .raddr  (raddr),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .wbe    (wbe),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        re    = 1'b0;
        raddr = '0;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        wbe   = '0;
    endtask

    // Counts edges while busy stays high, optionally hammering re/we the whole time
    task automatic run_clear(input int limit, input bit abuse, output int n, output bit rv);
        n  = 0;
        rv = 1'b0;
        if (abuse) begin
            re    = 1'b1;
            raddr = 10'h005;
            we    = 1'b1;
            waddr = 10'h005;
            wdata = 32'hFFFF_FFFF;
            wbe   = 4'hF;
        end
        while (busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
            if (rvalid) rv = 1'b1;
        end
        idle_inputs();
    endtask

    task automatic read_one(input string name, input logic [9:0] addr, input logic [31:0] exp);
        @(negedge clk);
        re    = 1'b1;
        raddr = addr;
        @(posedge clk);
        #1;
        check({name, "_rvalid"}, 32'(rvalid), 32'd1);
        check({name, "_rdata"}, rdata, exp);
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 10'h000, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[1]  = '{1'b1, 10'h3FF, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[2]  = '{1'b0, 10'h000, 1'b1, 10'h155, 32'hDEADBEEF,  4'hF, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 10'h155, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 10'h000, 1'b0, 10'h000, 32'h0,         4'h0, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 10'h000, 1'b1, 10'h155, 32'h11223344,  4'h5, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 10'h155, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'hDE22BE44};
        vecs[7]  = '{1'b0, 10'h000, 1'b1, 10'h010, 32'hAAAAAAAA,  4'hF, 1'b0, 32'hDE22BE44};
        vecs[8]  = '{1'b1, 10'h010, 1'b1, 10'h010, 32'h12345678,  4'h3, 1'b1, EXP_COLL};
        vecs[9]  = '{1'b1, 10'h010, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'hAAAA5678};
        vecs[10] = '{1'b0, 10'h000, 1'b1, 10'h0FF, 32'h0BADF00D,  4'hF, 1'b0, 32'hAAAA5678};
        vecs[11] = '{1'b0, 10'h000, 1'b1, 10'h100, 32'hCAFEF00D,  4'hF, 1'b0, 32'hAAAA5678};
        vecs[12] = '{1'b1, 10'h0FF, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'h0BADF00D};
        vecs[13] = '{1'b1, 10'h100, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'hCAFEF00D};
        vecs[14] = '{1'b1, 10'h200, 1'b1, 10'h200, 32'hFFFFFFFF,  4'h0, 1'b1, 32'h0};
        vecs[15] = '{1'b1, 10'h200, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'h0};
        vecs[16] = '{1'b0, 10'h000, 1'b1, 10'h155, 32'h0,         4'h0, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 10'h155, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'hDE22BE44};
        vecs[18] = '{1'b1, 10'h0FF, 1'b1, 10'h3FF, 32'h55AA55AA,  4'hF, 1'b1, 32'h0BADF00D};
        vecs[19] = '{1'b1, 10'h3FF, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'h55AA55AA};
        vecs[20] = '{1'b1, 10'h2FF, 1'b1, 10'h300, 32'h77665544,  4'hC, 1'b1, 32'h0};
        vecs[21] = '{1'b1, 10'h300, 1'b0, 10'h000, 32'h0,         4'h0, 1'b1, 32'h77660000};

        reset = 1'b1;
        idle_inputs();
        #1;
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        repeat (3) @(posedge clk);

        @(negedge clk);
        reset = 1'b0;
        run_clear(3000, 1'b0, cyc, rv_seen);
        check("clear_cycles", 32'(cyc), 32'd1024);
        check("clear_busy_low", 32'(busy), 32'd0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            re    = vecs[i].re;
            raddr = vecs[i].raddr;
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            wbe   = vecs[i].wbe;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(vecs[i].exp_rvalid));
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            idle_inputs();
        end

        // Reset during the clear: 500 busy cycles, then restart from scratch
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_clear(500, 1'b0, cyc, rv_seen);
        check("midclr_partial_cycles", 32'(cyc), 32'd500);
        check("midclr_still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midclr_reset_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_clear(3000, 1'b0, cyc, rv_seen);
        check("midclr_full_cycles", 32'(cyc), 32'd1024);
        read_one("midclr_cleared_155", 10'h155, 32'h0);

        // Reset while a read is in flight: result dropped, rdata forced to zero
        read_one("prime_read_3ff", 10'h3FF, 32'h0);
        @(negedge clk);
        re    = 1'b1;
        raddr = 10'h3FF;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrd_rvalid", 32'(rvalid), 32'd0);
        check("midrd_rdata", rdata, 32'h0);
        check("midrd_busy", 32'(busy), 32'd1);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        run_clear(3000, 1'b1, cyc, rv_seen);
        check("abuse_clear_cycles", 32'(cyc), 32'd1024);
        check("abuse_no_rvalid", 32'(rv_seen), 32'd0);
        read_one("abuse_addr_005", 10'h005, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
